// File: rtl/output_port_tx.sv
`timescale 1ns/1ps
// output_port_tx
// Transmit side of a router output port. Flits from the crossbar are staged
// in a small FIFO and pushed onto the inter-router link one per cycle while
// the downstream input buffer signals "on". Wormhole framing (head..tail) is
// enforced on the link: out-of-order flit types are popped and dropped, and
// a sticky error flag is raised.
//
// Handshake: a flit is accepted on any rising edge where flit_in_valid and
// flit_in_ready are both high. flit_in_ready depends only on FIFO occupancy
// (never on flit_in_valid), so it drops only when the FIFO is full, even if
// a pop happens in the same cycle.
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           synchronous active-high reset
//   flit_in       64-bit flit, [63:62] type: 01 head, 00 body, 10 tail, 11 head+tail
//   flit_in_valid flit_in valid this cycle
//   flit_in_ready FIFO can accept (not full)
//   buffer_on_in  downstream buffer on/off (1 = may send), registered once
//   flit_o        flit on link, registered, holds when not valid
//   flit_o_valid  one-cycle push into the downstream buffer
//   pkt_active    wormhole lock (FSM state: head sent, tail not yet sent)
//   proto_err     sticky framing error, cleared only by rst
//   tx_count      number of flits transmitted, wraps
module output_port_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      flit_in,
    input  logic             flit_in_valid,
    output logic             flit_in_ready,
    input  logic             buffer_on_in,
    output logic [63:0]      flit_o,
    output logic             flit_o_valid,
    output logic             pkt_active,
    output logic             proto_err,
    output logic [CNT_W-1:0] tx_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [63:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        on_q;
    logic        full;
    logic        empty;
    logic        accept;
    logic        pop;
    logic        legal;
    logic [63:0] front;
    logic [1:0]  front_type;

    assign full          = (count == (AW+1)'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign flit_in_ready = ~full;
    assign accept        = flit_in_valid & ~full;
    assign pop           = ~empty & on_q;
    assign front         = mem[rd_ptr];
    assign front_type    = front[63:62];
    assign pkt_active    = (state == PACKET);

    // Framing check on the FIFO front. An illegal flit is still popped so a
    // stray flit cannot wedge the port; it just never reaches the link.
    always_comb begin
        state_n = state;
        legal   = 1'b0;
        case (state)
            IDLE: begin
                case (front_type)
                    2'b01: begin
                        legal   = 1'b1;
                        state_n = PACKET;
                    end
                    2'b11: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            PACKET: begin
                case (front_type)
                    2'b00: legal = 1'b1;
                    2'b10: begin
                        legal   = 1'b1;
                        state_n = IDLE;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: begin
                state_n = IDLE;
                legal   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (pop) begin
            state <= state_n;
        end
    end

    // Storage carries no reset; rst empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            on_q   <= 1'b1;
        end else begin
            on_q <= buffer_on_in;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_o       <= '0;
            flit_o_valid <= 1'b0;
            proto_err    <= 1'b0;
            tx_count     <= '0;
        end else begin
            flit_o_valid <= pop & legal;
            if (pop & legal) begin
                flit_o   <= front;
                tx_count <= tx_count + 1'b1;
            end
            if (pop & ~legal) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
